// File: rtl/ahb_xfer_scheduler.sv
// Round-robin read/write word scheduler in front of a single-word AHB master.
// One request in flight at a time; buffers gate issue only while idle.
module ahb_xfer_scheduler #(
  parameter int CNT_W     = 16,
  parameter int ADDR_STEP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_start,
  input  logic [31:0]      rd_base,
  input  logic [CNT_W-1:0] rd_count,
  input  logic             wr_start,
  input  logic [31:0]      wr_base,
  input  logic [CNT_W-1:0] wr_count,
  input  logic             rd_buf_full,
  input  logic             wr_data_valid,
  input  logic             read_complete,
  input  logic             write_complete,
  output logic             re,
  output logic             we,
  output logic [31:0]      next_raddr,
  output logic [31:0]      next_waddr,
  output logic             rd_word_done,
  output logic             wr_word_pop,
  output logic             rd_busy,
  output logic             wr_busy,
  output logic             rd_done,
  output logic             wr_done,
  output logic             proto_err
);

  typedef enum logic [2:0] {
    IDLE, ISSUE_RD, WAIT_RD, ISSUE_WR, WAIT_WR
  } state_t;

  state_t           state, state_nx;
  logic             last_wr;
  logic [CNT_W-1:0] rd_rem, wr_rem;
  logic [31:0]      rd_addr, wr_addr;
  logic             rd_elig, wr_elig;
  logic             grant_rd, grant_wr;
  logic             rd_cpl, wr_cpl;
  logic             rd_last, wr_last;
  logic             rd_load, wr_load;

  assign rd_elig  = rd_busy & ~rd_buf_full;
  assign wr_elig  = wr_busy & wr_data_valid;
  assign grant_rd = rd_elig & (~wr_elig | last_wr);
  assign grant_wr = wr_elig & (~rd_elig | ~last_wr);

  assign rd_cpl  = (state == WAIT_RD) & read_complete;
  assign wr_cpl  = (state == WAIT_WR) & write_complete;
  assign rd_last = rd_cpl & (rd_rem == CNT_W'(1));
  assign wr_last = wr_cpl & (wr_rem == CNT_W'(1));
  // A start landing on the final completion re-arms the channel at once
  assign rd_load = rd_start & (~rd_busy | rd_last);
  assign wr_load = wr_start & (~wr_busy | wr_last);

  assign re         = (state == ISSUE_RD);
  assign we         = (state == ISSUE_WR);
  assign next_raddr = rd_addr;
  assign next_waddr = wr_addr;

  // State register and round-robin memory of the last granted channel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      last_wr <= 1'b1;
    end else begin
      state <= state_nx;
      if (state == ISSUE_RD) last_wr <= 1'b0;
      if (state == ISSUE_WR) last_wr <= 1'b1;
    end
  end

  // Next-state: grant in IDLE, one-cycle issue, wait for own completion
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          grant_rd: state_nx = ISSUE_RD;
          grant_wr: state_nx = ISSUE_WR;
          default:  state_nx = IDLE;
        endcase
      end
      ISSUE_RD: state_nx = WAIT_RD;
      WAIT_RD:  if (read_complete) state_nx = IDLE;
      ISSUE_WR: state_nx = WAIT_WR;
      WAIT_WR:  if (write_complete) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // Read channel: counter, address and per-word/done pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_rem       <= '0;
      rd_addr      <= '0;
      rd_busy      <= 1'b0;
      rd_word_done <= 1'b0;
      rd_done      <= 1'b0;
    end else begin
      rd_word_done <= rd_cpl;
      rd_done      <= rd_last | (rd_load & (rd_count == '0));
      if (rd_cpl) begin
        rd_rem  <= rd_rem - CNT_W'(1);
        rd_addr <= rd_addr + 32'(ADDR_STEP);
        if (rd_last) rd_busy <= 1'b0;
      end
      if (rd_load) begin
        rd_rem  <= rd_count;
        rd_addr <= rd_base;
        rd_busy <= (rd_count != '0);
      end
    end
  end

  // Write channel: counter, address and per-word/done pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_rem      <= '0;
      wr_addr     <= '0;
      wr_busy     <= 1'b0;
      wr_word_pop <= 1'b0;
      wr_done     <= 1'b0;
    end else begin
      wr_word_pop <= wr_cpl;
      wr_done     <= wr_last | (wr_load & (wr_count == '0));
      if (wr_cpl) begin
        wr_rem  <= wr_rem - CNT_W'(1);
        wr_addr <= wr_addr + 32'(ADDR_STEP);
        if (wr_last) wr_busy <= 1'b0;
      end
      if (wr_load) begin
        wr_rem  <= wr_count;
        wr_addr <= wr_base;
        wr_busy <= (wr_count != '0);
      end
    end
  end

  // Sticky flag for completions arriving when not waiting for them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      proto_err <= 1'b0;
    end else begin
      if ((read_complete & (state != WAIT_RD)) |
          (write_complete & (state != WAIT_WR)))
        proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ahb_xfer_scheduler.sv
// Bench for ahb_xfer_scheduler: AHB responder with random wait states,
// issue log compared against a round-robin grant model.
module tb_ahb_xfer_scheduler;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             rd_start, wr_start;
  logic [31:0]      rd_base, wr_base;
  logic [CNT_W-1:0] rd_count, wr_count;
  logic             rd_buf_full, wr_data_valid;
  logic             read_complete, write_complete;
  logic             re, we;
  logic [31:0]      next_raddr, next_waddr;
  logic             rd_word_done, wr_word_pop;
  logic             rd_busy, wr_busy, rd_done, wr_done;
  logic             proto_err;

  int errors = 0;
  int checks = 0;

  string       glog;
  int          n_iss, n_rw, n_rd, n_wp, n_wd, n_both, n_stab, n_rdal, n_wdal;
  bit          rd_pend, wr_pend, auto_rsp;
  logic [31:0] rd_ia, wr_ia;

  ahb_xfer_scheduler #(.CNT_W(CNT_W), .ADDR_STEP(4)) dut (
    .clk(clk), .rst(rst),
    .rd_start(rd_start), .rd_base(rd_base), .rd_count(rd_count),
    .wr_start(wr_start), .wr_base(wr_base), .wr_count(wr_count),
    .rd_buf_full(rd_buf_full), .wr_data_valid(wr_data_valid),
    .read_complete(read_complete), .write_complete(write_complete),
    .re(re), .we(we),
    .next_raddr(next_raddr), .next_waddr(next_waddr),
    .rd_word_done(rd_word_done), .wr_word_pop(wr_word_pop),
    .rd_busy(rd_busy), .wr_busy(wr_busy),
    .rd_done(rd_done), .wr_done(wr_done),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  // Expected issue sequence: alternate when both have words, last grant starts as WR
  function automatic string model(logic [31:0] rb, int rc,
                                  logic [31:0] wb, int wc);
    string s;
    bit    last, g;
    s = "";
    last = 1'b1;
    while (rc > 0 || wc > 0) begin
      if (rc > 0 && wc > 0) g = !last;
      else g = (wc > 0);
      if (g) begin
        s = {s, $sformatf("W%08h ", wb)};
        wb = wb + 32'd4;
        wc--;
      end else begin
        s = {s, $sformatf("R%08h ", rb)};
        rb = rb + 32'd4;
        rc--;
      end
      last = g;
    end
    return s;
  endfunction

  // Monitor: log issues and pulses mid-cycle
  initial begin
    forever begin
      @(negedge clk);
      if (re && we) n_both++;
      if (re) begin
        glog = {glog, $sformatf("R%08h ", next_raddr)};
        n_iss++;
        rd_pend = 1'b1;
        rd_ia = next_raddr;
      end
      if (we) begin
        glog = {glog, $sformatf("W%08h ", next_waddr)};
        n_iss++;
        wr_pend = 1'b1;
        wr_ia = next_waddr;
      end
      if (read_complete && rd_pend) begin
        if (next_raddr !== rd_ia) n_stab++;
        rd_pend = 1'b0;
      end
      if (write_complete && wr_pend) begin
        if (next_waddr !== wr_ia) n_stab++;
        wr_pend = 1'b0;
      end
      if (rd_word_done) n_rw++;
      if (wr_word_pop) n_wp++;
      if (rd_done) n_rd++;
      if (wr_done) n_wd++;
      if (rd_done && rd_word_done && !rd_busy) n_rdal++;
      if (wr_done && wr_word_pop && !wr_busy) n_wdal++;
    end
  end

  // AHB master stand-in: completes each request after 0..2 wait states
  initial begin : rsp
    bit w;
    int ws;
    forever begin
      @(posedge clk);
      #1;
      if (auto_rsp && (re || we)) begin
        w = we;
        ws = $urandom_range(0, 2);
        repeat (1 + ws) @(posedge clk);
        #1;
        if (w) write_complete = 1'b1;
        else read_complete = 1'b1;
        @(posedge clk);
        #1;
        read_complete = 1'b0;
        write_complete = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    auto_rsp = 1'b0;
    rst = 1'b1;
    rd_start = 1'b0; wr_start = 1'b0;
    rd_base = '0; wr_base = '0;
    rd_count = '0; wr_count = '0;
    rd_buf_full = 1'b0; wr_data_valid = 1'b0;
    read_complete = 1'b0; write_complete = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    glog = "";
    n_iss = 0; n_rw = 0; n_rd = 0; n_wp = 0; n_wd = 0;
    n_both = 0; n_stab = 0; n_rdal = 0; n_wdal = 0;
    rd_pend = 1'b0; wr_pend = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_done(input int er, input int ew, input string nm);
    int i;
    for (i = 0; i < 400; i++) begin
      if (n_rd >= er && n_wd >= ew) break;
      tick();
    end
    checks++;
    if (i == 400) begin
      errors++;
      $display("FAIL %s timeout: rd_done=%0d wr_done=%0d want %0d/%0d",
               nm, n_rd, n_wd, er, ew);
    end
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if ({re, we, rd_word_done, wr_word_pop, rd_busy, wr_busy,
         rd_done, wr_done, proto_err} !== 9'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 0",
               {re, we, rd_word_done, wr_word_pop, rd_busy, wr_busy,
                rd_done, wr_done, proto_err});
    end
    checks++;
    if ({next_raddr, next_waddr} !== 64'h0) begin
      errors++;
      $display("FAIL reset_addr: got %h/%h want 0/0", next_raddr, next_waddr);
    end
    apply_reset();
    checks++;
    if ({re, we, rd_busy, wr_busy, proto_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_idle: got %b want 0", {re, we, rd_busy, wr_busy, proto_err});
    end
  endtask

  task automatic test_read_only();
    string exp;
    apply_reset();
    auto_rsp = 1'b1;
    rd_base = 32'h1000; rd_count = 16'd3; rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    wait_done(1, 0, "read_only");
    exp = "R00001000 R00001004 R00001008 ";
    checks++;
    if (glog != exp) begin
      errors++;
      $display("FAIL read_only_order: got '%s' want '%s'", glog, exp);
    end
    checks++;
    if (n_rw != 3 || n_rd != 1 || n_rdal != 1) begin
      errors++;
      $display("FAIL read_only_pulses: got word=%0d done=%0d aligned=%0d want 3/1/1",
               n_rw, n_rd, n_rdal);
    end
    checks++;
    if (n_stab != 0 || rd_busy !== 1'b0) begin
      errors++;
      $display("FAIL read_only_stab: got unstable=%0d busy=%b want 0/0", n_stab, rd_busy);
    end
  endtask

  task automatic test_round_robin();
    string exp;
    apply_reset();
    auto_rsp = 1'b1;
    wr_data_valid = 1'b1;
    rd_base = 32'h2000; rd_count = 16'd2; rd_start = 1'b1;
    wr_base = 32'h3000; wr_count = 16'd2; wr_start = 1'b1;
    tick();
    rd_start = 1'b0; wr_start = 1'b0;
    wait_done(1, 1, "round_robin");
    exp = "R00002000 W00003000 R00002004 W00003004 ";
    checks++;
    if (glog != exp) begin
      errors++;
      $display("FAIL round_robin_order: got '%s' want '%s'", glog, exp);
    end
    checks++;
    if (n_both != 0 || n_rw != 2 || n_wp != 2 || n_wdal != 1) begin
      errors++;
      $display("FAIL round_robin_pulses: got both=%0d rw=%0d wp=%0d wal=%0d want 0/2/2/1",
               n_both, n_rw, n_wp, n_wdal);
    end
  endtask

  task automatic test_backpressure();
    string exp;
    int i;
    apply_reset();
    auto_rsp = 1'b1;
    wr_data_valid = 1'b1;
    rd_buf_full = 1'b1;
    rd_base = 32'h4000; rd_count = 16'd2; rd_start = 1'b1;
    wr_base = 32'h5000; wr_count = 16'd4; wr_start = 1'b1;
    tick();
    rd_start = 1'b0; wr_start = 1'b0;
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (n_iss >= 2) break;
    end
    rd_buf_full = 1'b0;
    wait_done(1, 1, "backpressure");
    exp = "W00005000 W00005004 R00004000 W00005008 R00004004 W0000500c ";
    checks++;
    if (glog != exp) begin
      errors++;
      $display("FAIL backpressure_order: got '%s' want '%s'", glog, exp);
    end
  endtask

  task automatic test_wrap();
    string exp;
    apply_reset();
    auto_rsp = 1'b1;
    rd_base = 32'hFFFF_FFFC; rd_count = 16'd2; rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    wait_done(1, 0, "wrap");
    exp = "Rfffffffc R00000000 ";
    checks++;
    if (glog != exp) begin
      errors++;
      $display("FAIL wrap_order: got '%s' want '%s'", glog, exp);
    end
    checks++;
    if (next_raddr !== 32'h4) begin
      errors++;
      $display("FAIL wrap_final_addr: got %h want 00000004", next_raddr);
    end
  endtask

  task automatic test_count_zero();
    apply_reset();
    auto_rsp = 1'b1;
    rd_count = 16'd0; rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    checks++;
    if ({rd_done, rd_busy, re} !== 3'b100) begin
      errors++;
      $display("FAIL zero_pulse: got done/busy/re=%b want 100", {rd_done, rd_busy, re});
    end
    tick();
    checks++;
    if (rd_done !== 1'b0) begin
      errors++;
      $display("FAIL zero_one_cycle: got done=%b want 0", rd_done);
    end
    repeat (6) tick();
    checks++;
    if (n_iss != 0 || n_rd != 1) begin
      errors++;
      $display("FAIL zero_no_issue: got issues=%0d done=%0d want 0/1", n_iss, n_rd);
    end
  endtask

  task automatic test_start_while_busy();
    string exp;
    apply_reset();
    auto_rsp = 1'b1;
    rd_base = 32'h6000; rd_count = 16'd2; rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    tick();
    rd_base = 32'h7000; rd_count = 16'd5; rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    wait_done(1, 0, "start_busy");
    repeat (10) tick();
    exp = "R00006000 R00006004 ";
    checks++;
    if (glog != exp || n_rd != 1) begin
      errors++;
      $display("FAIL start_busy_ignored: got '%s' done=%0d want '%s' done=1",
               glog, n_rd, exp);
    end
  endtask

  task automatic test_start_at_last();
    string exp;
    int i;
    apply_reset();
    rd_base = 32'h8000; rd_count = 16'd1; rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    for (i = 0; i < 20; i++) begin
      if (re) break;
      tick();
    end
    tick();
    read_complete = 1'b1;
    rd_base = 32'h9000; rd_count = 16'd2; rd_start = 1'b1;
    tick();
    read_complete = 1'b0; rd_start = 1'b0;
    checks++;
    if ({rd_done, rd_word_done, rd_busy} !== 3'b111 || next_raddr !== 32'h9000) begin
      errors++;
      $display("FAIL start_at_last: got done/word/busy=%b addr=%h want 111 00009000",
               {rd_done, rd_word_done, rd_busy}, next_raddr);
    end
    auto_rsp = 1'b1;
    wait_done(2, 0, "start_at_last");
    exp = "R00008000 R00009000 R00009004 ";
    checks++;
    if (glog != exp) begin
      errors++;
      $display("FAIL start_at_last_order: got '%s' want '%s'", glog, exp);
    end
  endtask

  task automatic test_reset_mid();
    int i;
    apply_reset();
    wr_data_valid = 1'b1;
    wr_base = 32'hA000; wr_count = 16'd3; wr_start = 1'b1;
    tick();
    wr_start = 1'b0;
    for (i = 0; i < 20; i++) begin
      if (we) break;
      tick();
    end
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({re, we, wr_busy, wr_word_pop, wr_done, proto_err} !== 6'b0 ||
        next_waddr !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid: got flags=%b waddr=%h want 0/0",
               {re, we, wr_busy, wr_word_pop, wr_done, proto_err}, next_waddr);
    end
    tick();
    rst = 1'b0;
    repeat (8) tick();
    checks++;
    if (n_iss != 1 || wr_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_after: got issues=%0d busy=%b want 1/0", n_iss, wr_busy);
    end
  endtask

  task automatic test_stray();
    apply_reset();
    checks++;
    if (proto_err !== 1'b0) begin
      errors++;
      $display("FAIL stray_pre: got proto_err=%b want 0", proto_err);
    end
    write_complete = 1'b1;
    tick();
    write_complete = 1'b0;
    checks++;
    if (proto_err !== 1'b1) begin
      errors++;
      $display("FAIL stray_set: got proto_err=%b want 1", proto_err);
    end
    repeat (5) tick();
    checks++;
    if (proto_err !== 1'b1 || n_wp != 0 || n_iss != 0) begin
      errors++;
      $display("FAIL stray_held: got err=%b pops=%0d issues=%0d want 1/0/0",
               proto_err, n_wp, n_iss);
    end
  endtask

  task automatic test_random();
    string       exp;
    int          rc, wc;
    logic [31:0] rb, wb;
    for (int it = 0; it < 8; it++) begin
      apply_reset();
      auto_rsp = 1'b1;
      wr_data_valid = 1'b1;
      rc = $urandom_range(0, 5);
      wc = $urandom_range(0, 5);
      rb = $urandom;
      wb = $urandom;
      rd_base = rb; rd_count = 16'(rc); rd_start = 1'b1;
      wr_base = wb; wr_count = 16'(wc); wr_start = 1'b1;
      tick();
      rd_start = 1'b0; wr_start = 1'b0;
      wait_done(1, 1, "random");
      exp = model(rb, rc, wb, wc);
      checks++;
      if (glog != exp) begin
        errors++;
        $display("FAIL random_order[%0d]: got '%s' want '%s'", it, glog, exp);
      end
      checks++;
      if (n_rw != rc || n_wp != wc || n_both != 0 || n_stab != 0) begin
        errors++;
        $display("FAIL random_pulses[%0d]: got rw=%0d wp=%0d both=%0d unstable=%0d want %0d/%0d/0/0",
                 it, n_rw, n_wp, n_both, n_stab, rc, wc);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    auto_rsp = 1'b0;
    rd_start = 1'b0; wr_start = 1'b0;
    rd_base = '0; wr_base = '0;
    rd_count = '0; wr_count = '0;
    rd_buf_full = 1'b0; wr_data_valid = 1'b0;
    read_complete = 1'b0; write_complete = 1'b0;
    glog = "";
    test_reset();
    test_read_only();
    test_round_robin();
    test_backpressure();
    test_wrap();
    test_count_zero();
    test_start_while_busy();
    test_start_at_last();
    test_reset_mid();
    test_stray();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
